// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction bytes over a req/ack handshake
// and presents each one to the decoder with a valid strobe.
module instruction_fetch #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [7:0]        imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [7:0]        instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        instr_q, instr_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= 8'h00;
            pc_out_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    pc_d     = pc_q + ADDR_W'(1);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // Stall freezes everything; halt outranks a redirect.
                if (!stall) begin
                    if (halt) begin
                        state_d = HALT;
                    end else begin
                        if (redirect) pc_d = redirect_pc;
                        state_d = FETCH;
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ISSUE);
    assign halted      = (state_q == HALT);
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       reset, imem_req, imem_ack, stall, redirect, halt;
    logic [7:0] imem_addr, imem_rdata, redirect_pc, instr, pc_out;
    logic       instr_valid, halted;
    logic [7:0] mem [256];

    int tests = 0;
    int fails = 0;

    instruction_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .instr(instr), .instr_valid(instr_valid),
        .pc_out(pc_out), .halted(halted)
    );

    always #5 clk = ~clk;

    // Memory answers whatever address the fetch unit drives.
    assign imem_rdata = mem[imem_addr];

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: phases named after the fetch unit's states.
    localparam int P_IDLE = 0, P_FETCH = 1, P_ISSUE = 2, P_HALT = 3;
    int         m_phase;
    bit         m_known = 1'b0;
    logic [7:0] m_pc, m_instr, m_pcout;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_known = 1'b1;
                m_phase = P_IDLE;
                m_pc    = 8'h00;
                m_instr = 8'h00;
                m_pcout = 8'h00;
            end else if (m_known) begin
                if (m_phase == P_IDLE) m_phase = P_FETCH;
                else if (m_phase == P_FETCH) begin
                    if (imem_ack) begin
                        m_instr = mem[m_pc];
                        m_pcout = m_pc;
                        m_pc    = 8'((int'(m_pc) + 1) % 256);
                        m_phase = P_ISSUE;
                    end
                end else if (m_phase == P_ISSUE && !stall) begin
                    if (halt) m_phase = P_HALT;
                    else begin
                        if (redirect) m_pc = redirect_pc;
                        m_phase = P_FETCH;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_known) begin
                chk("m_req", {7'd0, imem_req}, {7'd0, m_phase == P_FETCH});
                chk("m_valid", {7'd0, instr_valid}, {7'd0, m_phase == P_ISSUE});
                chk("m_halted", {7'd0, halted}, {7'd0, m_phase == P_HALT});
                chk("m_instr", instr, m_instr);
                chk("m_pc_out", pc_out, m_pcout);
                if (m_phase == P_FETCH) chk("m_addr", imem_addr, m_pc);
            end
        end
    end

    initial begin
        logic [7:0] seq [3];
        seq[0] = 8'h10; seq[1] = 8'h21; seq[2] = 8'h32;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        halt = 1'b0; imem_ack = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h10; mem[1] = 8'h21; mem[2] = 8'h32; mem[5] = 8'hC1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_req", {7'd0, imem_req}, 8'd0);
        chk("rst_valid", {7'd0, instr_valid}, 8'd0);
        chk("rst_halted", {7'd0, halted}, 8'd0);
        chk("rst_instr", instr, 8'h00);
        chk("rst_addr", imem_addr, 8'h00);

        // Zero-wait sequential fetch.
        imem_ack = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("seq_req", {7'd0, imem_req}, 8'd1);
            chk("seq_addr", imem_addr, 8'(k));
            tick();
            chk("seq_valid", {7'd0, instr_valid}, 8'd1);
            chk("seq_instr", instr, seq[k]);
            chk("seq_pc_out", pc_out, 8'(k));
            chk("seq_req_off", {7'd0, imem_req}, 8'd0);
            if (k < 2) tick();
        end

        // Redirect to 5, then three wait cycles.
        redirect = 1'b1; redirect_pc = 8'h05; imem_ack = 1'b0;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wait_req", {7'd0, imem_req}, 8'd1);
            chk("wait_addr", imem_addr, 8'h05);
            if (i == 3) imem_ack = 1'b1;
            tick();
        end

        // Stall three cycles with redirect and a late ack present.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 8'h80;
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", {7'd0, instr_valid}, 8'd1);
            chk("stall_instr", instr, 8'hC1);
            chk("stall_req", {7'd0, imem_req}, 8'd0);
            if (i == 3) begin stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0; end
            tick();
        end
        chk("stall_next_req", {7'd0, imem_req}, 8'd1);
        chk("stall_next_addr", imem_addr, 8'h06);

        // Wrap from 0xFF and a redirect to 0x40.
        imem_ack = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 8'hFF;
        tick();
        redirect = 1'b0;
        chk("wrap_addr_ff", imem_addr, 8'hFF);
        tick();
        chk("wrap_pc_out", pc_out, 8'hFF);
        tick();
        chk("wrap_addr_00", imem_addr, 8'h00);
        tick();
        redirect = 1'b1; redirect_pc = 8'h40;
        tick();
        redirect = 1'b0;
        chk("redir_addr", imem_addr, 8'h40);
        chk("redir_req", {7'd0, imem_req}, 8'd1);
        tick(); tick();
        chk("redir_next_addr", imem_addr, 8'h41);

        // Halt beats redirect; stays halted regardless of acks.
        tick();
        halt = 1'b1; redirect = 1'b1; redirect_pc = 8'h90;
        tick();
        halt = 1'b0; redirect = 1'b0;
        chk("halt_halted", {7'd0, halted}, 8'd1);
        chk("halt_valid", {7'd0, instr_valid}, 8'd0);
        for (int i = 0; i < 20; i++) begin
            imem_ack = 1'($urandom);
            tick();
            chk("halt_req", {7'd0, imem_req}, 8'd0);
        end

        // Reset from HALT and from a FETCH wait.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rsth_req", {7'd0, imem_req}, 8'd0);
        chk("rsth_halted", {7'd0, halted}, 8'd0);
        chk("rsth_instr", instr, 8'h00);
        imem_ack = 1'b0;
        tick();
        chk("rstf_req", {7'd0, imem_req}, 8'd1);
        tick();
        chk("rstf_addr", imem_addr, 8'h00);
        reset = 1'b1; imem_ack = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstf_req_off", {7'd0, imem_req}, 8'd0);
        chk("rstf_valid", {7'd0, instr_valid}, 8'd0);
        tick();
        chk("restart_addr", imem_addr, 8'h00);
        tick();
        chk("restart_instr", instr, 8'h10);

        // Randomized traffic; the model checks every cycle.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 99) == 0);
            stall       = ($urandom_range(0, 2) == 0);
            redirect    = ($urandom_range(0, 3) == 0);
            redirect_pc = 8'($urandom);
            halt        = ($urandom_range(0, 39) == 0);
            imem_ack    = 1'($urandom_range(0, 1));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
